// File: rtl/instr_encoder.sv
// RV32 instruction encoder: {kind, alu_op, regs, imm} requests in, 32-bit words out.
// Encoded words queue in a small FIFO and drain over a valid/ready port.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [3:0]       req_alu_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [19:0]      req_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_word,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    localparam logic [1:0] K_LOAD  = 2'b00;
    localparam logic [1:0] K_IMM   = 2'b01;
    localparam logic [1:0] K_STORE = 2'b10;
    localparam logic [1:0] K_REG   = 2'b11;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rr_ok;
    logic        is_shift;
    logic [31:0] enc_word;
    logic        enc_ok;

    // funct3/funct7 shared by register and immediate ALU forms
    always_comb begin
        f3       = 3'b000;
        f7       = 7'h00;
        rr_ok    = 1'b1;
        is_shift = 1'b0;
        unique case (req_alu_op)
            4'b0001: f3 = 3'b000;
            4'b0010: f7 = 7'h20;
            4'b0110: begin
                f3       = 3'b001;
                is_shift = 1'b1;
            end
            4'b1010: f3 = 3'b010;
            4'b1011: f3 = 3'b011;
            4'b0011: f3 = 3'b100;
            4'b0111: begin
                f3       = 3'b101;
                is_shift = 1'b1;
            end
            4'b1001: begin
                f3       = 3'b101;
                f7       = 7'h20;
                is_shift = 1'b1;
            end
            4'b0100: f3 = 3'b110;
            4'b0101: f3 = 3'b111;
            4'b1110: f7 = 7'h01;
            4'b1111: begin
                f3 = 3'b100;
                f7 = 7'h01;
            end
            default: rr_ok = 1'b0;
        endcase
    end

    always_comb begin
        enc_word = 32'h0000_0013;
        enc_ok   = 1'b1;
        if (req_alu_op != 4'b0000) begin
            unique case (req_kind)
                K_REG: begin
                    enc_ok   = rr_ok;
                    enc_word = {f7, req_rs2, req_rs1, f3, req_rd, OP_REG};
                end
                K_IMM: begin
                    if (req_alu_op == 4'b1101) begin
                        enc_word = {req_imm, req_rd, OP_AUIPC};
                    end else begin
                        // no immediate form of SUB or the M-extension ops
                        enc_ok = rr_ok && (req_alu_op != 4'b0010)
                                 && (f7 != 7'h01);
                        if (is_shift) begin
                            enc_word = {f7, req_imm[4:0], req_rs1,
                                        f3, req_rd, OP_IMM};
                        end else begin
                            enc_word = {req_imm[11:0], req_rs1,
                                        f3, req_rd, OP_IMM};
                        end
                    end
                end
                K_LOAD: begin
                    enc_ok   = (req_alu_op == 4'b0001);
                    enc_word = {req_imm[11:0], req_rs1, 3'b010,
                                req_rd, OP_LOAD};
                end
                K_STORE: begin
                    enc_ok   = (req_alu_op == 4'b0001);
                    enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010,
                                req_imm[4:0], OP_STORE};
                end
                default: enc_ok = 1'b0;
            endcase
        end
    end

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] mem [DEPTH];
    logic        empty;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                   && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign req_ready  = !full;
    assign inst_valid = !empty;
    assign inst_word  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

    assign accept = req_valid && req_ready;
    assign push   = accept && enc_ok && !flush;
    assign pop    = inst_valid && inst_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            illegal       <= 1'b0;
            illegal_count <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            illegal <= accept && !enc_ok;
            if (accept && !enc_ok && (illegal_count != '1)) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= enc_word;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, FIFO corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [3:0]       req_alu_op;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [19:0]      req_imm;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst_word;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_alu_op(req_alu_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference: per-op funct fields by mnemonic
    int unsigned t_f3 [16];
    int unsigned t_f7 [16];
    bit          t_ok [16];

    function automatic void def_op(int op, int unsigned f3, int unsigned f7);
        t_f3[op] = f3;
        t_f7[op] = f7;
        t_ok[op] = 1'b1;
    endfunction

    function automatic void init_tabs();
        for (int i = 0; i < 16; i++) begin
            t_f3[i] = 0; t_f7[i] = 0; t_ok[i] = 1'b0;
        end
        def_op(1, 0, 0);      // ADD
        def_op(2, 0, 32);     // SUB
        def_op(6, 1, 0);      // SLL
        def_op(10, 2, 0);     // SLT
        def_op(11, 3, 0);     // SLTU
        def_op(3, 4, 0);      // XOR
        def_op(7, 5, 0);      // SRL
        def_op(9, 5, 32);     // SRA
        def_op(4, 6, 0);      // OR
        def_op(5, 7, 0);      // AND
        def_op(14, 0, 1);     // MUL
        def_op(15, 4, 1);     // DIV
    endfunction

    function automatic logic [31:0] ref_enc(
        input int unsigned k, input int unsigned op,
        input int unsigned rd, input int unsigned rs1,
        input int unsigned rs2, input int unsigned imm,
        output bit ok);
        int unsigned w;
        int unsigned i12;
        int unsigned hi;
        i12 = imm % 4096;
        w   = 0;
        ok  = 1'b1;
        if (op == 0) return 32'h13;
        case (k)
            3: begin
                ok = t_ok[op];
                w = t_f7[op] * 2**25 + rs2 * 2**20 + rs1 * 2**15
                    + t_f3[op] * 4096 + rd * 128 + 51;
            end
            1: begin
                if (op == 13) begin
                    w = imm * 4096 + rd * 128 + 23;
                end else begin
                    ok = t_ok[op] && op != 2 && op != 14 && op != 15;
                    if (op == 6 || op == 7 || op == 9)
                        hi = t_f7[op] * 32 + imm % 32;
                    else
                        hi = i12;
                    w = hi * 2**20 + rs1 * 2**15 + t_f3[op] * 4096
                        + rd * 128 + 19;
                end
            end
            0: begin
                ok = (op == 1);
                w = i12 * 2**20 + rs1 * 2**15 + 8192 + rd * 128 + 3;
            end
            default: begin
                ok = (op == 1);
                w = (i12 / 32) * 2**25 + rs2 * 2**20 + rs1 * 2**15
                    + 8192 + (i12 % 32) * 128 + 35;
            end
        endcase
        return w;
    endfunction

    typedef struct {
        logic [1:0]  k;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [19:0] imm;
        logic [31:0] exp;
        bit          ill;
    } vec_t;

    vec_t vecs [14];

    task automatic set_req(input logic [1:0] k, input logic [3:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [19:0] imm);
        req_kind = k; req_alu_op = op;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] words [5];
    int          mcnt;
    bit          mill;
    bit          ok;
    bit          rv;
    bit          ir;
    bit          acc;
    bit          pp;
    logic [31:0] w;

    initial begin
        init_tabs();
        vecs[0]  = '{2'b11, 4'b0001, 5'd3, 5'd1, 5'd2, 20'h0, 32'h002081B3, 1'b0};
        vecs[1]  = '{2'b01, 4'b1001, 5'd5, 5'd6, 5'd0, 20'h3, 32'h40335293, 1'b0};
        vecs[2]  = '{2'b11, 4'b1110, 5'd10, 5'd11, 5'd12, 20'h0, 32'h02C58533, 1'b0};
        vecs[3]  = '{2'b10, 4'b0001, 5'd0, 5'd2, 5'd7, 20'h8, 32'h00712423, 1'b0};
        vecs[4]  = '{2'b11, 4'b0011, 5'd4, 5'd5, 5'd6, 20'h0, 32'h0062C233, 1'b0};
        vecs[5]  = '{2'b00, 4'b0001, 5'd1, 5'd2, 5'd0, 20'h4, 32'h00412083, 1'b0};
        vecs[6]  = '{2'b01, 4'b1101, 5'd1, 5'd0, 5'd0, 20'h12345, 32'h12345097, 1'b0};
        vecs[7]  = '{2'b01, 4'b0001, 5'd1, 5'd0, 5'd0, 20'hFFF, 32'hFFF00093, 1'b0};
        vecs[8]  = '{2'b01, 4'b0110, 5'd1, 5'd1, 5'd0, 20'hFFFE5, 32'h00509093, 1'b0};
        vecs[9]  = '{2'b10, 4'b0000, 5'd31, 5'd9, 5'd9, 20'hABCDE, 32'h00000013, 1'b0};
        vecs[10] = '{2'b00, 4'b0010, 5'd1, 5'd1, 5'd1, 20'h0, 32'h0, 1'b1};
        vecs[11] = '{2'b11, 4'b1000, 5'd1, 5'd1, 5'd1, 20'h0, 32'h0, 1'b1};
        vecs[12] = '{2'b01, 4'b1110, 5'd1, 5'd1, 5'd1, 20'h1, 32'h0, 1'b1};
        vecs[13] = '{2'b10, 4'b0011, 5'd1, 5'd1, 5'd1, 20'h1, 32'h0, 1'b1};

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
        set_req(2'b00, 4'b0000, 5'd0, 5'd0, 5'd0, 20'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", inst_valid, 0);
        chk("rst_word", inst_word, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_count", illegal_count, 0);
        chk("rst_ready", req_ready, 1);

        foreach (vecs[i]) begin
            set_req(vecs[i].k, vecs[i].op, vecs[i].rd, vecs[i].rs1,
                    vecs[i].rs2, vecs[i].imm);
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            if (vecs[i].ill) begin
                chk($sformatf("vec%0d_illegal", i), illegal, 1);
                chk($sformatf("vec%0d_noenq", i), inst_valid, 0);
                tick();
                chk($sformatf("vec%0d_pulse", i), illegal, 0);
            end else begin
                chk($sformatf("vec%0d_valid", i), inst_valid, 1);
                chk($sformatf("vec%0d_word", i), inst_word, vecs[i].exp);
                chk($sformatf("vec%0d_noill", i), illegal, 0);
                inst_ready = 1'b1;
                tick();
                inst_ready = 1'b0;
                chk($sformatf("vec%0d_drained", i), inst_valid, 0);
            end
        end

        // fill to full, then pop with a push offered in the same cycle
        for (int i = 0; i < 5; i++)
            words[i] = ref_enc(3, 1, i + 1, 1, 2, 0, ok);
        for (int i = 0; i < 4; i++) begin
            set_req(2'b11, 4'b0001, 5'(i + 1), 5'd1, 5'd2, 20'h0);
            req_valid = 1'b1;
            tick();
        end
        chk("full_ready", req_ready, 0);
        chk("full_head", inst_word, words[0]);
        set_req(2'b11, 4'b0001, 5'd5, 5'd1, 5'd2, 20'h0);
        inst_ready = 1'b1;
        tick();
        req_valid = 1'b0; inst_ready = 1'b0;
        chk("full_pop_ready", req_ready, 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), inst_valid, 1);
            chk($sformatf("drain%0d_word", i), inst_word, words[i]);
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
        end
        chk("drain_empty", inst_valid, 0);

        // flush drops queued words and a concurrent push
        set_req(2'b11, 4'b0001, 5'd1, 5'd1, 5'd2, 20'h0);
        req_valid = 1'b1;
        tick(); tick();
        flush = 1'b1; inst_ready = 1'b1;
        tick();
        flush = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
        chk("flush_empty", inst_valid, 0);
        chk("flush_word", inst_word, 0);
        chk("flush_count_kept", illegal_count, 4);
        tick();
        chk("flush_push_dropped", inst_valid, 0);

        // illegal pulse and counter saturation
        reset = 1'b1; #1 reset = 1'b0;
        set_req(2'b01, 4'b0010, 5'd1, 5'd1, 5'd0, 20'h1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("subi_illegal", illegal, 1);
        chk("subi_count", illegal_count, 1);
        chk("subi_noenq", inst_valid, 0);
        tick();
        chk("subi_pulse_end", illegal, 0);
        req_valid = 1'b1;
        repeat (299) @(posedge clk);
        #1 req_valid = 1'b0;
        chk("sat_count", illegal_count, 255);
        chk("sat_illegal", illegal, 1);
        chk("sat_noenq", inst_valid, 0);

        // randomized traffic against queue model
        reset = 1'b1; #1 reset = 1'b0;
        q.delete(); mcnt = 0;
        for (int c = 0; c < 600; c++) begin
            rv = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 2) == 0);
            set_req(2'($urandom), 4'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 20'($urandom));
            req_valid = rv; inst_ready = ir;
            w = ref_enc(req_kind, req_alu_op, req_rd, req_rs1, req_rs2,
                        req_imm, ok);
            acc = rv && (q.size() < DEPTH);
            pp  = ir && (q.size() > 0);
            tick();
            if (pp) void'(q.pop_front());
            mill = 1'b0;
            if (acc) begin
                if (ok) q.push_back(w);
                else begin
                    mill = 1'b1;
                    if (mcnt < 255) mcnt++;
                end
            end
            chk("rnd_valid", inst_valid, q.size() > 0);
            chk("rnd_word", inst_word, (q.size() > 0) ? q[0] : 32'h0);
            chk("rnd_ready", req_ready, q.size() < DEPTH);
            chk("rnd_illegal", illegal, mill);
            chk("rnd_count", illegal_count, mcnt);
        end
        req_valid = 1'b0; inst_ready = 1'b0;

        // async reset with words queued
        reset = 1'b1; #1 reset = 1'b0;
        set_req(2'b11, 4'b0001, 5'd3, 5'd1, 5'd2, 20'h0);
        req_valid = 1'b1;
        tick(); tick();
        req_valid = 1'b0;
        chk("pre_reset_valid", inst_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", inst_valid, 0);
        chk("async_word", inst_word, 0);
        chk("async_ready", req_ready, 1);
        chk("async_count", illegal_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_req(2'b11, 4'b0000, 5'd7, 5'd8, 5'd9, 20'h55);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("post_reset_nop_valid", inst_valid, 1);
        chk("post_reset_nop", inst_word, 32'h00000013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
